// File: rtl/ip_psram_arbiter_pkg.sv
// Shared definitions for the two-port PSRAM arbiter: FSM state encoding,
// request op codes and the watchdog counter width helper.
package ip_psram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  localparam int TMO_W_MIN = 10;

  // Watchdog counter width: wide enough for the timeout, never below 10 bits.
  function automatic int tmo_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < TMO_W_MIN) ? TMO_W_MIN : w;
  endfunction

endpackage

// File: rtl/ip_psram_req_slot.sv
// One-entry request latch for one arbiter port.
// Ports:
//   clk, n_reset       clock, async active-low reset
//   rd, wr             request pulses; ignored while the slot is full
//   address, wdata     request address / write data, captured with rd/wr
//   clear              empties the slot (driven by the arbiter FSM)
//   full               slot holds a pending or in-service request
//   op, addr_q, data_q captured request
module ip_psram_req_slot
  import ip_psram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              full,
  output arb_op_t           op,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] data_q
);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      full   <= 1'b0;
      op     <= OP_RD;
      addr_q <= '0;
      data_q <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (!full && (rd || wr)) begin
      full   <= 1'b1;
      // simultaneous rd and wr: the read wins, the write is dropped
      op     <= rd ? OP_RD : OP_WR;
      addr_q <= address;
      data_q <= wdata;
    end
  end

endmodule

// File: rtl/ip_psram_arbiter.sv
// Shares one ip_psram channel between two requesters, one access at a time.
// Read data is returned only to the port that owns the access.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | waiting for mem_busy=0 and a full slot; issues rd/wr
//   ST_WAIT_BUSY | access issued, waiting for mem_busy to rise
//   ST_WAIT_DONE | waiting for mem_rdata_en (read) or mem_busy=0 (write)
//
// Ports:
//   clk, n_reset                            clock, async active-low reset
//   rdN, wrN, addressN, wdataN              port N request (N = 0, 1)
//   busyN, rdataN, rdataN_en                port N status / read return
//   mem_rd, mem_wr, mem_address, mem_wdata  channel to ip_psram
//   mem_busy, mem_rdata, mem_rdata_en       status / data from ip_psram
//   timeout_err                             sticky watchdog release flag
module ip_psram_arbiter
  import ip_psram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] address0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              busy0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rdata0_en,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] address1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              busy1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rdata1_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_en,
  output logic              timeout_err
);

  localparam int              CNT_W   = tmo_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  arb_state_t        state;
  logic              owner;
  arb_op_t           own_op;
  logic              rr_next;   // port that wins the next tie (round-robin)
  logic [CNT_W-1:0]  wd_cnt;

  logic              full0, full1, clear0, clear1;
  arb_op_t           op0, op1;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [DATA_W-1:0] data0_q, data1_q;

  ip_psram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .n_reset(n_reset), .rd(rd0), .wr(wr0), .address(address0), .wdata(wdata0),
    .clear(clear0), .full(full0), .op(op0), .addr_q(addr0_q), .data_q(data0_q)
  );

  ip_psram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .n_reset(n_reset), .rd(rd1), .wr(wr1), .address(address1), .wdata(wdata1),
    .clear(clear1), .full(full1), .op(op1), .addr_q(addr1_q), .data_q(data1_q)
  );

  assign busy0 = full0;
  assign busy1 = full1;

  logic own_rd, done, tmo, release_slot;
  assign own_rd = (own_op == OP_RD);

  always_comb begin
    done = 1'b0;
    case (state)
      ST_WAIT_BUSY: done = own_rd && mem_rdata_en;
      ST_WAIT_DONE: done = own_rd ? mem_rdata_en : !mem_busy;
      default:      done = 1'b0;
    endcase
  end

  // A genuine completion in the same cycle as the watchdog expiry wins.
  assign tmo          = (state != ST_IDLE) && !done && (wd_cnt == TMO_CNT);
  assign release_slot = done || tmo;
  assign clear0       = release_slot && !owner;
  assign clear1       = release_slot && owner;

  logic              grant_valid, grant_port;
  arb_op_t           sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    grant_port = 1'b0;
    if (full0 && full1)
      grant_port = (FIXED_PRIO != 0) ? 1'b0 : rr_next;
    else
      grant_port = !full0;
  end

  assign grant_valid = (state == ST_IDLE) && !mem_busy && (full0 || full1);
  assign sel_op      = grant_port ? op1 : op0;
  assign sel_addr    = grant_port ? addr1_q : addr0_q;
  assign sel_data    = grant_port ? data1_q : data0_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      own_op      <= OP_RD;
      rr_next     <= 1'b0;
      wd_cnt      <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
      rdata0_en   <= 1'b0;
      rdata1_en   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rdata0_en <= 1'b0;
      rdata1_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (grant_valid) begin
            owner       <= grant_port;
            own_op      <= sel_op;
            mem_rd      <= (sel_op == OP_RD);
            mem_wr      <= (sel_op == OP_WR);
            mem_address <= sel_addr;
            mem_wdata   <= sel_data;
            state       <= ST_WAIT_BUSY;
            // the pointer only moves when a tie was actually resolved
            if (full0 && full1)
              rr_next <= !grant_port;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (release_slot) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
            if (own_rd) begin
              if (!owner) begin
                rdata0    <= done ? mem_rdata : '0;
                rdata0_en <= 1'b1;
              end else begin
                rdata1    <= done ? mem_rdata : '0;
                rdata1_en <= 1'b1;
              end
            end
            if (tmo)
              timeout_err <= 1'b1;
          end else if ((state == ST_WAIT_BUSY) && mem_busy) begin
            state  <= ST_WAIT_DONE;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_psram_arbiter.sv
// Bench for ip_psram_arbiter: two instances (round-robin and fixed priority)
// driven by the same requests, each with its own small ip_psram model.
module tb_ip_psram_arbiter;

  localparam int AW = 22;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] address0 = '0, address1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic mute = 1'b0;

  logic [1:0] busy0, busy1, rdata0_en, rdata1_en, mem_rd, mem_wr, timeout_err;
  logic [1:0][DW-1:0] rdata0, rdata1, mem_wdata;
  logic [1:0][AW-1:0] mem_address;

  int checks = 0;
  int errors = 0;
  int n, s0, s1;
  logic flag;
  logic [AW-1:0] q0[$], q1[$];

  // instance 0: round-robin, instance 1: fixed priority
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic m_busy, m_en, m_rd_q, bad_issue;
    logic [DW-1:0] m_data;
    logic [2:0]    m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] mem [256];
    logic [255:0]  written;

    ip_psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g), .TIMEOUT(16)) u_dut (
      .clk(clk), .n_reset(n_reset),
      .rd0(rd0), .wr0(wr0), .address0(address0), .wdata0(wdata0),
      .busy0(busy0[g]), .rdata0(rdata0[g]), .rdata0_en(rdata0_en[g]),
      .rd1(rd1), .wr1(wr1), .address1(address1), .wdata1(wdata1),
      .busy1(busy1[g]), .rdata1(rdata1[g]), .rdata1_en(rdata1_en[g]),
      .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_address(mem_address[g]),
      .mem_wdata(mem_wdata[g]), .mem_busy(m_busy), .mem_rdata(m_data),
      .mem_rdata_en(m_en), .timeout_err(timeout_err[g])
    );

    // PSRAM model: busy rises the cycle after rd/wr, read data strobes while
    // still busy, busy falls one cycle later. Unwritten bytes read addr^0x3C.
    always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        m_busy <= 1'b0; m_en <= 1'b0; m_rd_q <= 1'b0; m_cnt <= '0;
        m_addr <= '0; m_data <= '0; written <= '0; bad_issue <= 1'b0;
      end else begin
        m_en <= 1'b0;
        if ((mem_rd[g] | mem_wr[g]) && m_busy) bad_issue <= 1'b1;
        if (m_busy) begin
          m_cnt <= m_cnt - 3'd1;
          if (m_cnt == 3'd3 && m_rd_q) begin
            m_en   <= 1'b1;
            m_data <= written[m_addr[7:0]] ? mem[m_addr[7:0]] : (m_addr[7:0] ^ 8'h3C);
          end
          if (m_cnt == 3'd1) m_busy <= 1'b0;
        end else if (!mute && (mem_rd[g] | mem_wr[g])) begin
          m_busy <= 1'b1;
          m_cnt  <= 3'd5;
          m_rd_q <= mem_rd[g];
          m_addr <= mem_address[g];
          if (mem_wr[g]) begin
            mem[mem_address[g][7:0]]     <= mem_wdata[g];
            written[mem_address[g][7:0]] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_rd[0] | mem_wr[0]) q0.push_back(mem_address[0]);
    if (mem_rd[1] | mem_wr[1]) q1.push_back(mem_address[1]);
  end

  typedef struct {
    logic          port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_rd;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic req(input logic port, input logic r, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!port) begin rd0 = r; wr0 = w; address0 = a; wdata0 = d; end
    else       begin rd1 = r; wr1 = w; address1 = a; wdata1 = d; end
  endtask

  task automatic idle_in();
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic do_vec(input int i);
    vec_t v;
    logic [1:0] bp, ep, eo;
    int cnt;
    logic other_bad;
    v = vt[i];
    @(negedge clk); req(v.port, v.rd, v.wr, v.addr, v.wdata);
    @(negedge clk); idle_in();
    bp = v.port ? busy1 : busy0;
    chk($sformatf("v%0d_busy_set", i), 32'(bp), 32'd3);
    chk($sformatf("v%0d_no_early_issue", i), 32'(mem_rd | mem_wr), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd), v.exp_rd ? 32'd3 : 32'd0);
    chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr), v.exp_rd ? 32'd0 : 32'd3);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("v%0d_addr_dut%0d", i, g), 32'(mem_address[g]), 32'(v.addr));
      if (!v.exp_rd) chk($sformatf("v%0d_wdata_dut%0d", i, g), 32'(mem_wdata[g]), 32'(v.wdata));
    end
    cnt = 0; other_bad = 1'b0;
    while (cnt < 40) begin
      bp = v.port ? busy1 : busy0;
      ep = v.port ? rdata1_en : rdata0_en;
      eo = v.port ? rdata0_en : rdata1_en;
      if (eo != 2'b00) other_bad = 1'b1;
      if (v.exp_rd ? (ep == 2'b11) : (bp == 2'b00)) break;
      @(negedge clk); cnt++;
    end
    chk($sformatf("v%0d_completed", i), 32'(cnt < 40), 32'd1);
    chk($sformatf("v%0d_busy_clear", i), 32'(v.port ? busy1 : busy0), 32'd0);
    if (v.exp_rd)
      for (int g = 0; g < 2; g++)
        chk($sformatf("v%0d_rdata_dut%0d", i, g), 32'(v.port ? rdata1[g] : rdata0[g]), 32'(v.exp_data));
    chk($sformatf("v%0d_other_en", i), 32'(other_bad), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic [AW-1:0] exp_rr[4];
  logic [AW-1:0] exp_fp[4];

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    //          port  rd    wr    addr         wdata  exp_rd exp_data
    vt[0] = '{1'b0, 1'b0, 1'b1, 22'h000123, 8'h5A, 1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b1, 1'b0, 22'h000123, 8'h00, 1'b1, 8'h5A};
    vt[2] = '{1'b1, 1'b0, 1'b1, 22'h00ABCD, 8'h3C, 1'b0, 8'h00};
    vt[3] = '{1'b1, 1'b1, 1'b0, 22'h00ABCD, 8'h00, 1'b1, 8'h3C};
    vt[4] = '{1'b0, 1'b1, 1'b1, 22'h3FFFFF, 8'h77, 1'b1, 8'hC3};  // write dropped
    vt[5] = '{1'b1, 1'b1, 1'b0, 22'h000123, 8'h00, 1'b1, 8'h5A};
    vt[6] = '{1'b1, 1'b1, 1'b0, 22'h000042, 8'h00, 1'b1, 8'h7E};
    vt[7] = '{1'b1, 1'b1, 1'b0, 22'h000077, 8'h00, 1'b1, 8'h4B};  // after reset
    exp_rr = '{22'h000123, 22'h00ABCD, 22'h00ABCD, 22'h000123};
    exp_fp = '{22'h000123, 22'h00ABCD, 22'h000123, 22'h00ABCD};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'({busy1, busy0}), 32'd0);
    chk("rst_mem_cmd", 32'({mem_wr, mem_rd}), 32'd0);
    chk("rst_addr", 32'(mem_address[0] | mem_address[1]), 32'd0);
    chk("rst_en", 32'({rdata1_en, rdata0_en}), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) do_vec(i);

    // ties: two rounds of simultaneous reads on both ports
    s0 = q0.size(); s1 = q1.size();
    repeat (2) begin
      @(negedge clk); req(1'b0, 1'b1, 1'b0, 22'h000123, 8'h00); req(1'b1, 1'b1, 1'b0, 22'h00ABCD, 8'h00);
      @(negedge clk); idle_in();
      n = 0;
      while (n < 80 && (busy0 | busy1) != 2'b00) begin @(negedge clk); n++; end
      chk("tie_round_done", 32'(n < 80), 32'd1);
      repeat (3) @(negedge clk);
    end
    chk("tie_count_rr", 32'(q0.size() - s0), 32'd4);
    chk("tie_count_fp", 32'(q1.size() - s1), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (s0 + k < q0.size()) chk($sformatf("tie_rr_grant%0d", k), 32'(q0[s0 + k]), 32'(exp_rr[k]));
      if (s1 + k < q1.size()) chk($sformatf("tie_fp_grant%0d", k), 32'(q1[s1 + k]), 32'(exp_fp[k]));
    end

    // port 0 latches while port 1 write is in service
    @(negedge clk); req(1'b1, 1'b0, 1'b1, 22'h000200, 8'h11);
    @(negedge clk); idle_in();
    n = 0;
    while (n < 10 && mem_wr[0] !== 1'b1) begin @(negedge clk); n++; end
    chk("s3_wr_issued", 32'(n < 10), 32'd1);
    rd0 = 1'b1; address0 = 22'h000123;
    @(negedge clk); rd0 = 1'b0;
    n = 0; flag = 1'b0;
    while (n < 40 && mem_rd[0] !== 1'b1) begin
      if (busy0 != 2'b11) flag = 1'b1;
      @(negedge clk); n++;
    end
    chk("s3_rd_issued", 32'(n < 40), 32'd1);
    chk("s3_busy0_held", 32'(flag), 32'd0);
    chk("s3_wr_released_first", 32'(busy1), 32'd0);
    chk("s3_rd_addr", 32'(mem_address[0]), 32'h000123);
    n = 0;
    while (n < 40 && rdata0_en != 2'b11) begin @(negedge clk); n++; end
    chk("s3_rd_done", 32'(n < 40), 32'd1);
    chk("s3_rdata_dut0", 32'(rdata0[0]), 32'h5A);
    chk("s3_rdata_dut1", 32'(rdata0[1]), 32'h5A);
    chk("s3_busy0_clear", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    chk("issue_while_busy", 32'({gen_dut[1].bad_issue, gen_dut[0].bad_issue}), 32'd0);

    // watchdog: memory never answers
    mute = 1'b1;
    @(negedge clk); req(1'b0, 1'b1, 1'b0, 22'h000055, 8'h00);
    @(negedge clk); idle_in();
    n = 0;
    while (n < 10 && mem_rd[0] !== 1'b1) begin @(negedge clk); n++; end
    chk("s5_rd_issued", 32'(n < 10), 32'd1);
    n = 0; flag = 1'b0;
    while (n < 40 && rdata0_en != 2'b11) begin
      if (rdata1_en != 2'b00) flag = 1'b1;
      @(negedge clk); n++;
    end
    // counter runs 0..16 in WAIT_BUSY; release edge follows the cycle at 16
    chk("s5_release_delay", 32'(n), 32'd17);
    chk("s5_rdata_zero", 32'({rdata0[1], rdata0[0]}), 32'd0);
    chk("s5_timeout_err", 32'(timeout_err), 32'd3);
    chk("s5_busy0_clear", 32'(busy0), 32'd0);
    chk("s5_other_en", 32'(flag), 32'd0);
    repeat (10) @(negedge clk);
    chk("s5_err_sticky", 32'(timeout_err), 32'd3);
    mute = 1'b0;
    n_reset = 1'b0; #1;
    chk("s5_err_reset", 32'(timeout_err), 32'd0);
    #1 n_reset = 1'b1;

    // async reset in WAIT_DONE
    @(negedge clk); req(1'b1, 1'b1, 1'b0, 22'h000077, 8'h00);
    @(negedge clk); idle_in();
    n = 0;
    while (n < 10 && mem_rd[0] !== 1'b1) begin @(negedge clk); n++; end
    chk("s6_rd_issued", 32'(n < 10), 32'd1);
    repeat (3) @(negedge clk);
    chk("s6_in_service", 32'(busy1), 32'd3);
    n_reset = 1'b0; #1;
    chk("s6_busy", 32'({busy1, busy0}), 32'd0);
    chk("s6_mem_cmd", 32'({mem_wr, mem_rd}), 32'd0);
    chk("s6_addr", 32'(mem_address[0] | mem_address[1]), 32'd0);
    chk("s6_en", 32'({rdata1_en, rdata0_en}), 32'd0);
    chk("s6_rdata1", 32'({rdata1[1], rdata1[0]}), 32'd0);
    #1 n_reset = 1'b1;
    do_vec(7);
    chk("final_issue_while_busy", 32'({gen_dut[1].bad_issue, gen_dut[0].bad_issue}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
